// File: rtl/soric_pkg.sv
// Shared types and constants for the Wishbone-to-interconnect bridge.
package soric_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    ACK,
    DRAIN
  } state_e;

  localparam logic [31:0] SORIC_TIMEOUT_DATA = 32'hDEAD_BEEF;
  localparam logic [31:0] SORIC_BASE_ADDR    = 32'h3000_0000;
  localparam logic [31:0] SORIC_BASE_MASK    = 32'hFFFF_C000;

  // Request fields captured at launch and held until grant.
  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } soric_req_t;

  function automatic logic soric_hit(input logic [31:0] adr,
                                     input logic [31:0] base,
                                     input logic [31:0] mask);
    return (adr & mask) == base;
  endfunction

endpackage

// File: rtl/soric_timeout_cnt.sv
// Loadable saturating cycle counter; done_o flags that MAX has been reached.
module soric_timeout_cnt #(
  parameter int unsigned MAX = 255
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic load_i,
  input  logic en_i,
  output logic done_o
);

  localparam int unsigned W = (MAX < 1) ? 1 : $clog2(MAX + 1);

  logic [W-1:0] cnt_q;

  assign done_o = (cnt_q == W'(MAX));

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)             cnt_q <= '0;
    else if (load_i)           cnt_q <= '0;
    else if (en_i && !done_o)  cnt_q <= cnt_q + W'(1);
  end

endmodule

// File: rtl/soric_wb_bridge.sv
// Registered Wishbone-classic slave to interconnect master bridge, one request in flight.
// Optional wait limit enabled by defining SORIC_WB_BRIDGE_TIMEOUT_EN.
module soric_wb_bridge
  import soric_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 14,
  parameter logic [31:0] BASE_ADDR      = SORIC_BASE_ADDR,
  parameter logic [31:0] BASE_MASK      = SORIC_BASE_MASK,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic                  data_req_o,
  output logic [ADDR_WIDTH-1:0] data_addr_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [31:0]           data_wdata_o,
  input  logic                  data_gnt_i,
  input  logic                  data_rvalid_i,
  input  logic [31:0]           data_rdata_i
);

  state_e                state_q, state_d;
  soric_req_t            lat_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  req_q, req_d;
  logic                  ack_q, guard_q;
  logic [31:0]           dat_q, dat_d;
  logic                  dat_ld, launch, hit, tmo_done;

  assign hit = soric_hit(wbs_adr_i, BASE_ADDR, BASE_MASK);

`ifdef SORIC_WB_BRIDGE_TIMEOUT_EN
  soric_timeout_cnt #(.MAX(TIMEOUT_CYCLES)) u_tmo (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .load_i   (launch),
    .en_i     (state_q == REQ || state_q == WAIT),
    .done_o   (tmo_done)
  );
`else
  logic [31:0] unused_tmo;
  assign unused_tmo = 32'(TIMEOUT_CYCLES);
  assign tmo_done   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    launch  = 1'b0;
    dat_ld  = 1'b0;
    dat_d   = lat_q.we ? 32'h0 : data_rdata_i;
    unique case (state_q)
      IDLE: begin
        if (wbs_stb_i && wbs_cyc_i && hit && !guard_q) begin
          launch  = 1'b1;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        // The request can never be withdrawn; an abort only suppresses the ack.
        if (data_gnt_i) begin
          req_d = 1'b0;
          if (data_rvalid_i) begin
            dat_ld  = wbs_cyc_i;
            state_d = wbs_cyc_i ? ACK : IDLE;
          end else begin
            state_d = wbs_cyc_i ? WAIT : DRAIN;
          end
        end else if (!wbs_cyc_i || tmo_done) begin
          state_d = DRAIN;
        end
      end
      WAIT: begin
        if (data_rvalid_i) begin
          dat_ld  = wbs_cyc_i;
          state_d = wbs_cyc_i ? ACK : IDLE;
        end else if (!wbs_cyc_i) begin
          state_d = DRAIN;
        end else if (tmo_done) begin
          dat_ld  = 1'b1;
          dat_d   = SORIC_TIMEOUT_DATA;
          state_d = ACK;
        end
      end
      ACK: state_d = IDLE;
      DRAIN: begin
        // req_q still high means the grant is outstanding as well as the response.
        if (req_q) begin
          if (data_gnt_i) begin
            req_d = 1'b0;
            if (data_rvalid_i) state_d = IDLE;
          end
        end else if (data_rvalid_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      ack_q   <= 1'b0;
      guard_q <= 1'b0;
      dat_q   <= '0;
      addr_q  <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      ack_q   <= (state_d == ACK);
      guard_q <= (state_q == ACK);
      if (dat_ld) dat_q <= dat_d;
      if (launch) begin
        addr_q      <= wbs_adr_i[ADDR_WIDTH-1:0];
        lat_q.we    <= wbs_we_i;
        lat_q.be    <= wbs_sel_i;
        lat_q.wdata <= wbs_dat_i;
      end
    end
  end

  assign wbs_ack_o    = ack_q;
  assign wbs_dat_o    = dat_q;
  assign data_req_o   = req_q;
  assign data_addr_o  = addr_q;
  assign data_we_o    = lat_q.we;
  assign data_be_o    = lat_q.be;
  assign data_wdata_o = lat_q.wdata;

endmodule

// File: tb/tb_soric_wb_bridge.sv
// Directed bench for soric_wb_bridge; timeout case follows SORIC_WB_BRIDGE_TIMEOUT_EN.
module tb_soric_wb_bridge;

  logic        clk, rst_n;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic        req;
  logic [13:0] daddr;
  logic        dwe;
  logic [3:0]  dbe;
  logic [31:0] dwdata;
  logic        gnt, rvalid;
  logic [31:0] rdata;

  int n_chk  = 0;
  int n_fail = 0;
  int hits;

  soric_wb_bridge #(.ADDR_WIDTH(14), .TIMEOUT_CYCLES(8)) dut (
    .clk_i         (clk),
    .reset_ni      (rst_n),
    .wbs_stb_i     (stb),
    .wbs_cyc_i     (cyc),
    .wbs_we_i      (we),
    .wbs_sel_i     (sel),
    .wbs_adr_i     (adr),
    .wbs_dat_i     (wdat),
    .wbs_ack_o     (ack),
    .wbs_dat_o     (rdat),
    .data_req_o    (req),
    .data_addr_o   (daddr),
    .data_we_o     (dwe),
    .data_be_o     (dbe),
    .data_wdata_o  (dwdata),
    .data_gnt_i    (gnt),
    .data_rvalid_i (rvalid),
    .data_rdata_i  (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_start(input logic [31:0] a, input logic w, input logic [3:0] s,
                          input logic [31:0] d);
    adr = a; we = w; sel = s; wdat = d; stb = 1'b1; cyc = 1'b1;
  endtask

  task automatic wb_stop();
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; stb = 0; cyc = 0; we = 0; sel = 0; adr = 0; wdat = 0;
    gnt = 0; rvalid = 0; rdata = 0;
    #12;
    chk("rst_req", req, 0);
    chk("rst_ack", ack, 0);
    chk("rst_dat", rdat, 0);
    chk("rst_addr", daddr, 0);
    chk("rst_we", dwe, 0);
    chk("rst_be", dbe, 0);
    chk("rst_wdata", dwdata, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    step();

    // read, gnt in cycle 1, rvalid in cycle 2, ack in cycle 3
    wb_start(32'h3000_0804, 1'b0, 4'hF, 32'h0);
    step();
    chk("rd_req_c1", req, 1);
    chk("rd_addr", daddr, 14'h0804);
    chk("rd_we", dwe, 0);
    gnt = 1;
    step();
    chk("rd_req_c2", req, 0);
    chk("rd_ack_c2", ack, 0);
    gnt = 0; rvalid = 1; rdata = 32'h1234_5678;
    step();
    chk("rd_ack_c3", ack, 1);
    chk("rd_dat_c3", rdat, 32'h1234_5678);
    rvalid = 0;
    step();
    chk("rd_ack_c4", ack, 0);
    step();
    chk("rd_guard_req", req, 0);
    wb_stop();
    step();

    // write with a 4-cycle grant delay; request fields must not follow the bus
    wb_start(32'h3000_2000, 1'b1, 4'b0011, 32'hA5A5_A5A5);
    step();
    adr = 32'h3000_0000; wdat = 32'h0; sel = 4'hF; we = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      chk("wr_req_held", req, 1);
      chk("wr_we", dwe, 1);
      chk("wr_be", dbe, 4'b0011);
      chk("wr_wdata", dwdata, 32'hA5A5_A5A5);
      chk("wr_addr", daddr, 14'h2000);
      if (i == 5) gnt = 1;
      step();
    end
    chk("wr_req_drop", req, 0);
    chk("wr_ack_early", ack, 0);
    gnt = 0; rvalid = 1; rdata = 32'hFFFF_FFFF;
    step();
    chk("wr_ack", ack, 1);
    chk("wr_dat_zero", rdat, 0);
    rvalid = 0; wb_stop();
    step();
    chk("wr_ack_once", ack, 0);
    step();

    // address misses, including the first address past the window
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      wb_start((i < 10) ? 32'h2000_0000 : 32'h3000_4000, 1'b0, 4'hF, 32'h0);
      step();
      if (req || ack) hits++;
    end
    chk("miss_activity", hits, 0);
    wb_stop();
    step();

    // abort in REQ before grant: request held, response absorbed, no ack
    wb_start(32'h3000_0010, 1'b0, 4'hF, 32'h0);
    step();
    chk("ab_req_c1", req, 1);
    wb_stop();
    step();
    chk("ab_req_held1", req, 1);
    step();
    chk("ab_req_held2", req, 1);
    gnt = 1;
    step();
    chk("ab_req_drop", req, 0);
    chk("ab_ack_gnt", ack, 0);
    gnt = 0; rvalid = 1; rdata = 32'h7777_7777;
    step();
    chk("ab_ack_rv", ack, 0);
    rvalid = 0;
    step();
    chk("ab_ack_idle", ack, 0);
    chk("ab_dat_kept", rdat, 0);
    chk("ab_req_idle", req, 0);

    // read at the top of the window with gnt and rvalid together
    wb_start(32'h3000_3FFC, 1'b0, 4'hF, 32'h0);
    step();
    chk("ab2_req", req, 1);
    chk("ab2_addr", daddr, 14'h3FFC);
    gnt = 1; rvalid = 1; rdata = 32'h0BAD_F00D;
    step();
    chk("ab2_ack_c2", ack, 1);
    chk("ab2_dat", rdat, 32'h0BAD_F00D);
    gnt = 0; rvalid = 0; wb_stop();
    step();
    chk("ab2_ack_once", ack, 0);
    step();

    // asynchronous reset while in WAIT
    wb_start(32'h3000_0100, 1'b1, 4'hF, 32'h1111_2222);
    step();
    gnt = 1;
    step();
    gnt = 0;
    #1 rst_n = 1'b0;
    #1;
    chk("ar_req", req, 0);
    chk("ar_ack", ack, 0);
    chk("ar_dat", rdat, 0);
    chk("ar_addr", daddr, 0);
    chk("ar_we", dwe, 0);
    chk("ar_be", dbe, 0);
    chk("ar_wdata", dwdata, 0);
    wb_stop();
    @(posedge clk); #1 rst_n = 1'b1;
    step();
    wb_start(32'h3000_0200, 1'b0, 4'hF, 32'h0);
    step();
    chk("ar2_req", req, 1);
    chk("ar2_addr", daddr, 14'h0200);
    gnt = 1;
    step();
    gnt = 0; rvalid = 1; rdata = 32'hCAFE_0001;
    step();
    chk("ar2_ack", ack, 1);
    chk("ar2_dat", rdat, 32'hCAFE_0001);
    rvalid = 0; wb_stop();
    step();
    step();

    // grant given, response withheld
    wb_start(32'h3000_0300, 1'b0, 4'hF, 32'h0);
    step();
    gnt = 1;
    step();
    gnt = 0;
    for (int c = 2; c <= 9; c++) begin
      chk("to_wait_noack", ack, 0);
      step();
    end
`ifdef SORIC_WB_BRIDGE_TIMEOUT_EN
    chk("to_ack", ack, 1);
    chk("to_dat", rdat, 32'hDEAD_BEEF);
    wb_stop();
    step();
    chk("to_ack_once", ack, 0);
    rvalid = 1; rdata = 32'h5555_5555;
    step();
    rvalid = 0;
    step();
    chk("to_stray_ack", ack, 0);
    chk("to_stray_dat", rdat, 32'hDEAD_BEEF);
`else
    chk("nt_still_wait", ack, 0);
    rvalid = 1; rdata = 32'h1357_9BDF;
    step();
    chk("nt_ack", ack, 1);
    chk("nt_dat", rdat, 32'h1357_9BDF);
    rvalid = 0; wb_stop();
    step();
    chk("nt_ack_once", ack, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
